// File: rtl/nand_nor_vector_checker.sv
// On-chip checker for a NAND/NOR gate pair: steps {a,b} through 00..11, counts result mismatches.
// done rises 4*(HOLD_CYCLES+1) cycles after start; start while busy is ignored (no backpressure).
module nand_nor_vector_checker #(
   parameter int HOLD_CYCLES = 4,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_out,
   output logic             b_out,
   input  logic             nand_in,
   input  logic             nor_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   localparam int              HC_W      = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      idx;
   logic [HC_W-1:0] hcnt;
   logic            launch;
   logic            exp_nand;
   logic            exp_nor;
   logic [1:0]      mism;
   logic [ERR_W:0]  err_sum;

   assign launch = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = DRIVE;
         DRIVE:      if (hcnt == HOLD_LAST) state_nxt = SAMPLE;
         SAMPLE:     state_nxt = (idx == 2'd3) ? DONE : DRIVE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Operands are a pure decode of state/idx so reset clears them with no clock edge.
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      a_out = 1'b0;
      b_out = 1'b0;
      case (state)
         DRIVE, SAMPLE: begin
            busy           = 1'b1;
            {a_out, b_out} = idx;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
      pass = done && (err_count == '0);
   end

   assign exp_nand = ~(a_out & b_out);
   assign exp_nor  = ~(a_out | b_out);
   assign mism     = {1'b0, nand_in != exp_nand} + {1'b0, nor_in != exp_nor};
   // One spare bit catches the carry out so the count clamps instead of wrapping.
   assign err_sum  = {1'b0, err_count} + (ERR_W+1)'(mism);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= 2'd0;
         hcnt      <= '0;
         err_count <= '0;
         fail_vec  <= 4'd0;
      end else if (launch) begin
         idx       <= 2'd0;
         hcnt      <= '0;
         err_count <= '0;
         fail_vec  <= 4'd0;
      end else begin
         case (state)
            DRIVE: hcnt <= (hcnt == HOLD_LAST) ? '0 : hcnt + HC_W'(1);
            SAMPLE: begin
               err_count <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
               if (mism != 2'd0) fail_vec[idx] <= 1'b1;
               if (idx != 2'd3) idx <= idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_nor_vector_checker.sv
// Drives two checkers (ERR_W=8 and ERR_W=2) with a fault-injectable NAND/NOR model and scores their reports.
module tb_nand_nor_vector_checker;

   localparam int HOLD    = 4;
   localparam int RUN_LEN = 4 * (HOLD + 1);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] nand_mask = 4'd0;
   logic [3:0] nor_mask  = 4'd0;

   logic       a0, b0, nand0, nor0, busy0, done0, pass0;
   logic [7:0] err0;
   logic [3:0] fv0;
   logic       a1, b1, nand1, nor1, busy1, done1, pass1;
   logic [1:0] err1;
   logic [3:0] fv1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Gate pair model: a set mask bit inverts that output whenever that {a,b} vector is applied.
   assign nand0 = ~(a0 & b0) ^ nand_mask[{a0, b0}];
   assign nor0  = ~(a0 | b0) ^ nor_mask[{a0, b0}];
   assign nand1 = ~(a1 & b1) ^ nand_mask[{a1, b1}];
   assign nor1  = ~(a1 | b1) ^ nor_mask[{a1, b1}];

   nand_nor_vector_checker #(.HOLD_CYCLES(HOLD), .ERR_W(8)) dut0 (
      .clk(clk), .rst(rst), .start(start), .a_out(a0), .b_out(b0),
      .nand_in(nand0), .nor_in(nor0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_vec(fv0)
   );

   nand_nor_vector_checker #(.HOLD_CYCLES(HOLD), .ERR_W(2)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1),
      .nand_in(nand1), .nor_in(nor1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fv1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_dut0"}, 32'({a0, b0, busy0, done0, pass0, err0, fv0}), 32'd0);
      chk({tag, "_dut1"}, 32'({a1, b1, busy1, done1, pass1, err1, fv1}), 32'd0);
   endtask

   // Assert reset between clock edges, expect immediate clear, then confirm IDLE after release.
   task automatic mid_reset(input string tag);
      #1 rst = 1'b1;
      #1 check_zero({tag, "_async"});
      rst = 1'b0;
      tick;
      check_zero({tag, "_idle"});
   endtask

   task automatic do_run(input logic [3:0] nm, input logic [3:0] rm, input int stray, input int rst_at);
      int         e;
      logic [1:0] ab;
      e         = $countones(nm) + $countones(rm);
      nand_mask = nm;
      nor_mask  = rm;
      start     = 1'b1;
      tick;
      start = 1'b0;
      chk("launch_dut0", 32'({a0, b0, busy0, done0, pass0, err0, fv0}), 32'({2'b00, 3'b100, 8'd0, 4'd0}));
      chk("launch_dut1", 32'({a1, b1, busy1, done1, pass1, err1, fv1}), 32'({2'b00, 3'b100, 2'd0, 4'd0}));
      for (int t = 1; t <= RUN_LEN; t++) begin
         start = (t == stray);
         tick;
         start = 1'b0;
         if (t == rst_at) begin
            mid_reset("midrun");
            return;
         end
         ab = (t < RUN_LEN) ? 2'(t / (HOLD + 1)) : 2'd0;
         chk("seq_dut0", 32'({a0, b0, busy0, done0}), 32'({ab, t < RUN_LEN, t == RUN_LEN}));
         chk("seq_dut1", 32'({a1, b1, busy1, done1}), 32'({ab, t < RUN_LEN, t == RUN_LEN}));
      end
      chk("err_dut0",  32'(err0), e);
      chk("err_dut1",  32'(err1), (e > 3) ? 3 : e);
      chk("fvec_dut0", 32'(fv0), 32'(nm | rm));
      chk("fvec_dut1", 32'(fv1), 32'(nm | rm));
      chk("pass_dut0", 32'(pass0), 32'(e == 0));
      chk("pass_dut1", 32'(pass1), 32'(e == 0));
      repeat ($urandom_range(1, 4)) tick;
      chk("hold_dut0", 32'({done0, busy0, a0, b0, pass0, err0, fv0}),
          32'({4'b1000, e == 0, 8'(e), nm | rm}));
   endtask

   initial begin
      tick;
      tick;
      rst = 1'b0;
      tick;
      check_zero("reset");

      do_run(4'b0000, 4'b0000, 0, 0);
      do_run(4'b1000, 4'b0000, 0, 0);
      do_run(4'b1111, 4'b1111, 0, 0);
      mid_reset("postrun");
      do_run(4'b0000, 4'b0000, 0, 0);
      do_run(4'b0000, 4'b0000, 0, 7);
      do_run(4'b0000, 4'b0000, 0, 0);
      do_run(4'b1111, 4'b1111, 3, 0);

      for (int i = 0; i < 16; i++) begin
         logic [3:0] nm;
         logic [3:0] rm;
         int         stray;
         int         rat;
         nm    = 4'($urandom_range(0, 15));
         rm    = 4'($urandom_range(0, 15));
         stray = $urandom_range(0, 25);
         rat   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, RUN_LEN) : 0;
         do_run(nm, rm, stray, rat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
